// File: rtl/line_mem_responder.sv
// Line-granular backing memory: accepts one refill/write-back, waits LATENCY cycles, then streams LINE_WORDS beats.
// Read beats hold under rdata_ready=0; write beats are taken whenever wdata_valid; requests are refused until idle.
module line_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_last,
    output logic                  wr_done
);
    localparam int BW    = $clog2(LINE_WORDS);
    localparam int WW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** WW;
    localparam int CW    = $clog2(LATENCY + 2);

    typedef enum logic [2:0] {IDLE, DELAY, RBURST, WBURST, ACK} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           lat_cnt;
    logic [BW-1:0]           beat;
    logic [WW-BW-1:0]        base_line;
    logic                    is_write;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [WW-1:0]           word_idx;
    logic                    req_fire, rd_fire, wr_fire, beat_last;
    logic                    unused_addr_bits;

    // Beat index occupies the low word-index bits, so it wraps inside the line.
    assign word_idx         = {base_line, beat};
    assign beat_last        = (beat == BW'(LINE_WORDS - 1));
    assign unused_addr_bits = ^req_addr[BW+1:0];

    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        rdata_last  = 1'b0;
        wr_done     = 1'b0;
        rdata       = '0;
        req_fire    = 1'b0;
        rd_fire     = 1'b0;
        wr_fire     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_fire = 1'b1;
                    if (LATENCY > 0)    state_nxt = DELAY;
                    else if (req_write) state_nxt = WBURST;
                    else                state_nxt = RBURST;
                end
            end
            DELAY: begin
                if (lat_cnt == CW'(1)) state_nxt = is_write ? WBURST : RBURST;
            end
            RBURST: begin
                rdata_valid = 1'b1;
                rdata       = mem[word_idx];
                rdata_last  = beat_last;
                rd_fire     = rdata_ready;
                if (rdata_ready && beat_last) state_nxt = IDLE;
            end
            WBURST: begin
                wdata_ready = 1'b1;
                wr_fire     = wdata_valid;
                if (wdata_valid && beat_last) state_nxt = ACK;
            end
            ACK: begin
                wr_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            beat      <= '0;
            base_line <= '0;
            is_write  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                base_line <= req_addr[ADDR_WIDTH-1:BW+2];
                is_write  <= req_write;
                beat      <= '0;
                lat_cnt   <= CW'(LATENCY);
            end else if (state == DELAY) begin
                lat_cnt <= lat_cnt - CW'(1);
            end
            if (rd_fire || wr_fire) beat <= beat + BW'(1);
        end
    end

    // Storage is deliberately outside the reset domain: contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[word_idx] <= wdata;
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench: instance 0 built with LATENCY=3, instance 1 with LATENCY=0.
module tb_line_mem_responder;
    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       req_valid, req_ready, req_write, wdata_valid, wdata_ready;
    logic [1:0]       rdata_valid, rdata_ready, rdata_last, wr_done;
    logic [1:0][11:0] req_addr;
    logic [1:0][31:0] wdata, rdata;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [2][1024];
    beat_t       exp_q [$];

    line_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LINE_WORDS(4), .LATENCY(3)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
        .wdata_valid(wdata_valid[0]), .wdata_ready(wdata_ready[0]), .wdata(wdata[0]),
        .rdata_valid(rdata_valid[0]), .rdata_ready(rdata_ready[0]), .rdata(rdata[0]),
        .rdata_last(rdata_last[0]), .wr_done(wr_done[0])
    );

    line_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LINE_WORDS(4), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
        .wdata_valid(wdata_valid[1]), .wdata_ready(wdata_ready[1]), .wdata(wdata[1]),
        .rdata_valid(rdata_valid[1]), .rdata_ready(rdata_ready[1]), .rdata(rdata[1]),
        .rdata_last(rdata_last[1]), .wr_done(wr_done[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 3 : 0;
    endfunction

    function automatic int line_base(input logic [11:0] addr);
        return int'(addr[11:4]) * 4;
    endfunction

    task automatic chk_reset_outputs(input int s);
        chk("rst_req_ready", req_ready[s], 1);
        chk("rst_wdata_ready", wdata_ready[s], 0);
        chk("rst_rdata_valid", rdata_valid[s], 0);
        chk("rst_rdata_last", rdata_last[s], 0);
        chk("rst_wr_done", wr_done[s], 0);
        chk("rst_rdata", rdata[s], 0);
    endtask

    // Handshake the request, then count cycles until the first beat is offered.
    task automatic request(input int s, input bit wr, input logic [11:0] addr);
        int n = 0;
        req_valid[s] = 1'b1;
        req_write[s] = wr;
        req_addr[s]  = addr;
        while (!req_ready[s] && n < 64) begin
            tick();
            n++;
        end
        chk("req_accept_wait", (n < 64) ? 1 : 0, 1);
        tick();
        req_valid[s] = 1'b0;
        n = 0;
        while (!(wr ? wdata_ready[s] : rdata_valid[s]) && n < 64) begin
            tick();
            n++;
        end
        chk(wr ? "wr_first_beat_lat" : "rd_first_beat_lat", n, lat_of(s));
    endtask

    task automatic write_line(input int s, input logic [11:0] addr, input logic [127:0] line);
        request(s, 1'b1, addr);
        for (int i = 0; i < 4; i++) begin
            wdata_valid[s] = 1'b1;
            wdata[s]       = line[32*i +: 32];
            chk("wdata_ready", wdata_ready[s], 1);
            tick();
            model[s][line_base(addr) + i] = line[32*i +: 32];
        end
        wdata_valid[s] = 1'b0;
        chk("wr_done_ack", wr_done[s], 1);
        chk("wdata_ready_ack", wdata_ready[s], 0);
        tick();
        chk("wr_done_pulse_end", wr_done[s], 0);
        chk("req_ready_after_wr", req_ready[s], 1);
    endtask

    // stall_cycles of rdata_ready=0 are applied while beat stall_beat is on offer.
    task automatic read_line(input int s, input logic [11:0] addr, input int stall_beat,
                             input int stall_cycles, input bit busy);
        int cyc    = 0;
        int taken  = 0;
        int stalls = stall_cycles;
        for (int i = 0; i < 4; i++) exp_q.push_back('{d: model[s][line_base(addr) + i], last: (i == 3)});
        request(s, 1'b0, addr);
        if (busy) begin
            req_valid[s] = 1'b1;
            req_write[s] = 1'b0;
            req_addr[s]  = 12'h080;
        end
        while (exp_q.size() > 0 && cyc < 64) begin
            if (busy) chk("busy_req_ready", req_ready[s], 0);
            if (taken == stall_beat && stalls > 0) begin
                rdata_ready[s] = 1'b0;
                stalls--;
            end else begin
                rdata_ready[s] = 1'b1;
            end
            chk("rdata_valid", rdata_valid[s], 1);
            if (rdata_valid[s]) begin
                chk("rdata", rdata[s], exp_q[0].d);
                chk("rdata_last", rdata_last[s], exp_q[0].last);
                if (rdata_ready[s]) begin
                    void'(exp_q.pop_front());
                    taken++;
                end
            end
            tick();
            cyc++;
        end
        rdata_ready[s] = 1'b0;
        chk("rd_beats_left", exp_q.size(), 0);
        exp_q.delete();
        chk("rd_burst_cycles", cyc, 4 + stall_cycles);
        chk("req_ready_after_rd", req_ready[s], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        foreach (model[i, j]) model[i][j] = '0;
        rst         = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        wdata_valid = '0;
        wdata       = '0;
        rdata_ready = '0;
        tick();
        tick();
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst = 1'b0;
        tick();

        write_line(0, 12'h040, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        // Refill of the same line with a stall on beat 1 and a refused request pending.
        read_line(0, 12'h048, 1, 2, 1'b1);
        // The pending 0x080 request is taken only now.
        read_line(0, 12'h080, -1, 0, 1'b0);

        // Reset lands while write beat 2 is on the bus.
        request(0, 1'b1, 12'h100);
        for (int i = 0; i < 2; i++) begin
            wdata_valid[0] = 1'b1;
            wdata[0]       = (i == 0) ? 32'h11111111 : 32'h22222222;
            tick();
            model[0][line_base(12'h100) + i] = wdata[0];
        end
        wdata_valid[0] = 1'b1;
        wdata[0]       = 32'h33333333;
        rst            = 1'b1;
        #1;
        chk_reset_outputs(0);
        tick();
        rst            = 1'b0;
        wdata_valid[0] = 1'b0;
        tick();
        chk("req_ready_after_rst", req_ready[0], 1);
        read_line(0, 12'h100, -1, 0, 1'b0);

        // Zero-latency build.
        write_line(1, 12'h000, {32'hdddd0003, 32'hcccc0002, 32'hbbbb0001, 32'haaaa0000});
        read_line(1, 12'h000, -1, 0, 1'b0);
        read_line(1, 12'h00c, 2, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
